pattern_tx: RTL and testbench
=============================

Name: pattern_tx

Overview:
Serial frame transmitter that drives the single-bit line consumed by the team's 0-then-1 sequence detector. The line idles high. Each accepted word goes out as one frame: start bit 0, marker bit 1, then DATA_W payload bits MSB-first. With DATA_W=4 the payload exactly covers the detector's four post-trigger cycles, so the detector returns to its idle state at the frame boundary. The block sits between a parallel producer (valid/ready) and the serial link.

Parameters:
DATA_W, 4, payload bits per frame (>=1); 4 keeps frames aligned with the detector.
IDLE_GAP, 0, extra idle-high cycles forced after each frame, beyond the mandatory one.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
tx_valid  input  1  producer has a word on tx_data
tx_data  input  DATA_W  payload word, sampled at handshake
tx_ready  output  1  block can accept a word; high only in IDLE
x_out  output  1  serial line, registered; idles 1
busy  output  1  high from the START cycle through the last GAP cycle
done  output  1  one-cycle pulse after the last payload bit has been driven

Behaviour:
- Reset (async, reset==0):
  - state=IDLE, x_out=1, busy=0, done=0, shift register and counters cleared.
  - tx_ready=1 once reset is released.
  - Reset mid-frame aborts the frame immediately; x_out returns to 1 with no partial bits afterwards.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid && tx_ready.
  - tx_ready is combinational from state (IDLE only); it does not depend on tx_valid.
  - tx_data is captured into the shift register at the handshake; later changes to tx_data are ignored.
- States and x_out value per cycle:
  - IDLE: x_out=1. On handshake go to START.
  - START: x_out=0, 1 cycle, then MARK.
  - MARK: x_out=1, 1 cycle, then DATA.
  - DATA: x_out=shreg[DATA_W-1], shift left each cycle. Lasts DATA_W cycles, counted by a bit counter of width $clog2(DATA_W+1).
  - After DATA: go to GAP if IDLE_GAP>0, else go to IDLE.
  - GAP: x_out=1 for IDLE_GAP cycles, then IDLE.
- Latency: the first start bit appears on x_out the cycle after the handshake edge.
- Frame period:
  - Back-to-back frames run with tx_valid held high: 2+DATA_W+IDLE_GAP+1 cycles per frame.
  - The trailing 1 is the IDLE cycle in which the next handshake occurs.
  - The line is therefore never low for two consecutive frame-boundary cycles.
- done: high for exactly the first cycle after the last DATA cycle (first GAP cycle, or the IDLE cycle).
- busy: high in START, MARK, DATA and GAP.
- A payload bit of 0 never restarts framing; the line contents are fixed by the state machine only.

Optional Feature:
Macro PATTERN_TX_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt [15:0], reset to 0.
  - Increments on each done pulse and wraps 16'hFFFF to 0.
  - Not incremented for frames aborted by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package pattern_pkg:
  - state enum typedef (IDLE, START, MARK, DATA, GAP).
  - Line level constants: LINE_IDLE=1'b1, START_BIT=1'b0, MARK_BIT=1'b1.
  - Default DATA_W.
- Optional sub-module pattern_shift (load/shift register with MSB output). Otherwise a single module.

Test Plan:
1. Release reset, tx_valid=0 for 10 cycles -> x_out=1, tx_ready=1, busy=0, done=0 throughout.
2. Send tx_data=4'b1010 (DATA_W=4, IDLE_GAP=0):
   - x_out after the handshake is 0,1,1,0,1,0,1.
   - done is high on the 7th cycle only.
   - A connected sequence detector drives y_out=1 on cycles 3-4 after the handshake and is in its idle state after cycle 6.
3. Hold tx_valid=1 with words 4'hF, 4'h0, 4'h5:
   - Three frames, 7-cycle period.
   - tx_ready is high only on cycles 0, 7 and 14.
   - 4'h0 payload gives x_out 0,1,0,0,0,0 with no spurious detector trigger.
4. IDLE_GAP=3, send 4'h9 -> x_out is 0,1,1,0,0,1,1,1,1,1; tx_ready returns high 10 cycles after the handshake; busy is high for 9 cycles.
5. Assert reset during the 2nd payload bit -> x_out=1 immediately (asynchronous), done never pulses, tx_ready=1 after release; the next frame is sent correctly.
6. With PATTERN_TX_FRAME_CNT_EN defined:
   - Send 3 frames -> frame_cnt=3.
   - Preload the count to 16'hFFFF via 65535 frames or a forced value, send 1 frame -> frame_cnt=0.

Source files
------------

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared states and line levels for the pattern_tx frame transmitter
package pattern_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        MARK  = 3'd2,
        DATA  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic MARK_BIT  = 1'b1;

    localparam int DEFAULT_DATA_W = 4;

endpackage

// File: rtl/pattern_shift.sv
// rtl/pattern_shift.sv - parallel-load, shift-left register exposing its MSB
module pattern_shift #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] load_data,
    output logic         msb
);

    logic [W-1:0] shreg_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shreg_q <= '0;
        end else if (load) begin
            shreg_q <= load_data;
        end else if (shift) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb = shreg_q[W-1];

endmodule

// File: rtl/pattern_tx.sv
// rtl/pattern_tx.sv - serial frame transmitter: start 0, marker 1, payload MSB-first
// Optional frame counter output enabled by PATTERN_TX_FRAME_CNT_EN.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int IDLE_GAP = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              x_out,
    output logic              busy,
    output logic              done
`ifdef PATTERN_TX_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             x_out_q, x_out_d;
    logic             done_q, done_d;
    logic             handshake;
    logic             shift_en;
    logic             shreg_msb;

    assign tx_ready  = (state_q == IDLE);
    assign handshake = tx_valid && tx_ready;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE:  if (handshake) state_d = START;
            START: state_d = MARK;
            MARK: begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    done_d    = 1'b1;
                    bit_cnt_d = '0;
                    gap_cnt_d = '0;
                    state_d   = (IDLE_GAP > 0) ? GAP : IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            GAP: begin
                if (gap_cnt_q == LAST_GAP) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The line is registered from the next state, so the shift register
    // advances on the same edge that the current MSB is latched onto x_out.
    assign shift_en = (state_d == DATA);

    always_comb begin
        x_out_d = LINE_IDLE;
        case (state_d)
            START:   x_out_d = START_BIT;
            MARK:    x_out_d = MARK_BIT;
            DATA:    x_out_d = shreg_msb;
            default: x_out_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            x_out_q   <= LINE_IDLE;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            x_out_q   <= x_out_d;
            done_q    <= done_d;
        end
    end

    pattern_shift #(
        .W(DATA_W)
    ) u_shift (
        .clock    (clock),
        .reset    (reset),
        .load     (handshake),
        .shift    (shift_en),
        .load_data(tx_data),
        .msb      (shreg_msb)
    );

    assign x_out = x_out_q;
    assign busy  = (state_q != IDLE);
    assign done  = done_q;

`ifdef PATTERN_TX_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cnt_q <= '0;
        end else if (done_q) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// tb/tb_pattern_tx.sv - bench for pattern_tx with IDLE_GAP=0 and IDLE_GAP=3 instances
module tb_pattern_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tx_valid = 1'b0;
    logic [3:0] tx_data = 4'h0;
    logic       rdy0, x0, busy0, done0;
    logic       rdy3, x3, busy3, done3;
`ifdef PATTERN_TX_FRAME_CNT_EN
    logic [15:0] fc0, fc3;
`endif

    int tot = 0;
    int bad = 0;

    always #5 clock = ~clock;

    pattern_tx #(.DATA_W(4), .IDLE_GAP(0)) dut0 (
        .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy0), .x_out(x0), .busy(busy0), .done(done0)
`ifdef PATTERN_TX_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    pattern_tx #(.DATA_W(4), .IDLE_GAP(3)) dut3 (
        .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(rdy3), .x_out(x3), .busy(busy3), .done(done3)
`ifdef PATTERN_TX_FRAME_CNT_EN
        , .frame_cnt(fc3)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        tx_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    // Called at a negedge with both instances idle; checks 7 cycles of dut0.
    task automatic send_check(input string nm, input logic [3:0] d,
                              input logic [6:0] exp_line, input logic [6:0] exp_done);
        logic [6:0] line;
        logic [6:0] dn;
        tx_valid = 1'b1;
        tx_data  = d;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            if (k == 0) begin
                tx_valid = 1'b0;
                tx_data  = ~d;
            end
            line[6-k] = x0;
            dn[6-k]   = done0;
        end
        chk({nm, "_line"}, 32'(line), 32'(exp_line));
        chk({nm, "_done"}, 32'(dn), 32'(exp_done));
    endtask

    typedef struct {
        string      nm;
        logic [3:0] data;
        logic [6:0] line;
        logic [6:0] dn;
    } vec_t;

    // Reference model: c = cycles since handshake (0 = idle), frame busy for c in 1..6+gap.
    int         mc[2];
    logic [3:0] mw[2];
    logic       mdone[2];
    int         gapv[2] = '{0, 3};

    function automatic logic exp_x(input int c, input logic [3:0] w);
        if (c == 0) return 1'b1;
        if (c == 1) return 1'b0;
        if (c == 2) return 1'b1;
        if (c <= 6) return w[6-c];
        return 1'b1;
    endfunction

    task automatic model_edge(input int g);
        int prev;
        prev = mc[g];
        if (mc[g] == 0) begin
            if (tx_valid) begin
                mc[g] = 1;
                mw[g] = tx_data;
            end
        end else if (mc[g] < 6 + gapv[g]) begin
            mc[g] = mc[g] + 1;
        end else begin
            mc[g] = 0;
        end
        mdone[g] = (prev == 6);
    endtask

    initial begin
        vec_t       vecs[4];
        logic [21:0] xv;
        logic [20:0] rv;
        logic [9:0]  gx, gr, gd;
        logic [3:0]  words[3];
        int          busy_cnt;
        int          idx;
        logic        hsprev;

        vecs[0] = '{"vecA", 4'hA, 7'b0110101, 7'b0000001};
        vecs[1] = '{"vecF", 4'hF, 7'b0111111, 7'b0000001};
        vecs[2] = '{"vec0", 4'h0, 7'b0100001, 7'b0000001};
        vecs[3] = '{"vec5", 4'h5, 7'b0101011, 7'b0000001};

        // reset state, then 10 idle cycles
        repeat (3) @(negedge clock);
        chk("in_reset0", 32'({x0, busy0, done0}), 32'b100);
        chk("in_reset3", 32'({x3, busy3, done3}), 32'b100);
        reset = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk("idle0", 32'({x0, rdy0, busy0, done0}), 32'b1100);
            chk("idle3", 32'({x3, rdy3, busy3, done3}), 32'b1100);
        end

        for (int i = 0; i < 4; i++) begin
            send_check(vecs[i].nm, vecs[i].data, vecs[i].line, vecs[i].dn);
            idle(12);
        end

        // back-to-back frames with tx_valid held
        words[0] = 4'hF; words[1] = 4'h0; words[2] = 4'h5;
        idx = 0;
        hsprev = 1'b0;
        tx_valid = 1'b1;
        tx_data  = words[0];
        for (int k = 0; k < 22; k++) begin
            if (k > 0) begin
                @(negedge clock);
                if (hsprev) begin
                    idx++;
                    if (idx < 3) tx_data = words[idx];
                    else tx_valid = 1'b0;
                end
            end
            xv[21-k] = x0;
            if (k <= 20) rv[20-k] = rdy0;
            hsprev = rdy0 && tx_valid;
        end
        chk("b2b_line", 32'(xv), 32'({1'b1, 7'b0111111, 7'b0100001, 7'b0101011}));
        chk("b2b_ready", 32'(rv), 32'(21'b100000010000001000000));
        idle(14);

        // IDLE_GAP=3 instance with 4'h9
        busy_cnt = 0;
        tx_valid = 1'b1;
        tx_data  = 4'h9;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (k == 1) begin
                tx_valid = 1'b0;
                tx_data  = 4'h6;
            end
            gx[10-k] = x3;
            gr[10-k] = rdy3;
            gd[10-k] = done3;
            busy_cnt += int'(busy3);
        end
        chk("gap_line", 32'(gx), 32'(10'b0110011111));
        chk("gap_ready", 32'(gr), 32'(10'b0000000001));
        chk("gap_done", 32'(gd), 32'(10'b0000001000));
        chk("gap_busy_cycles", 32'(busy_cnt), 32'd9);
        idle(12);

        // reset during the second payload bit of dut0's frame
        tx_valid = 1'b1;
        tx_data  = 4'hA;
        @(negedge clock);
        tx_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_x", 32'(x0), 32'd1);
        chk("abort_busy", 32'(busy0), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("abort_hold", 32'({x0, done0}), 32'b10);
        end
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            chk("after_abort", 32'({x0, rdy0, busy0, done0}), 32'b1100);
        end
        send_check("post_abort", 4'h5, 7'b0101011, 7'b0000001);
        idle(12);

        // randomized traffic on both instances against the model
        for (int g = 0; g < 2; g++) begin
            mc[g] = 0; mw[g] = 4'h0; mdone[g] = 1'b0;
        end
        for (int i = 0; i < 600; i++) begin
            tx_valid = ($urandom_range(0, 3) != 0);
            tx_data  = 4'($urandom);
            @(posedge clock);
            model_edge(0);
            model_edge(1);
            @(negedge clock);
            chk("rnd0", 32'({x0, rdy0, busy0, done0}),
                32'({exp_x(mc[0], mw[0]), mc[0] == 0, mc[0] != 0, mdone[0]}));
            chk("rnd3", 32'({x3, rdy3, busy3, done3}),
                32'({exp_x(mc[1], mw[1]), mc[1] == 0, mc[1] != 0, mdone[1]}));
        end
        idle(12);

`ifdef PATTERN_TX_FRAME_CNT_EN
        reset = 1'b0;
        @(negedge clock);
        chk("fc_reset", 32'(fc0), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            send_check("fc_frame", vecs[i].data, vecs[i].line, vecs[i].dn);
            idle(12);
        end
        chk("fc_three", 32'(fc0), 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
